// File: rtl/stream_feeder_pkg.sv
// stream_feeder_pkg: shared state encodings and sizing constants for the
// stream feeder and its word buffer.
package stream_feeder_pkg;

  typedef enum logic [1:0] {
    FEED_IDLE  = 2'd0,
    FEED_RUN   = 2'd1,
    FEED_FLUSH = 2'd2
  } feed_state_e;

  localparam int BYTES_PER_WORD = 8;
  localparam int BUF_DEPTH      = 2;

endpackage

// File: rtl/stream_feeder_word_buf.sv
// feeder_word_buf: two-entry 64-bit FIFO holding fetched words until the
// serializer has emitted them. Head is visible combinationally so the
// serializer can pick a byte in the same cycle it decides to emit.
module feeder_word_buf
  import stream_feeder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        wr_en,
  input  logic [63:0] wr_data,
  input  logic        rd_en,
  output logic [1:0]  count,
  output logic [63:0] head
);

  logic [63:0] mem_q [BUF_DEPTH];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        do_wr, do_rd;

  // A write into a full buffer is dropped; a read of an empty one is ignored.
  assign do_wr = wr_en && (count_q != 2'(BUF_DEPTH));
  assign do_rd = rd_en && (count_q != 2'd0);

  // Pointer and occupancy update; clear empties the buffer outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_wr) wr_ptr_d = ~wr_ptr_q;
      if (do_rd) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(do_wr) - 2'(do_rd);
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (!clear && do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/stream_feeder.sv
// stream_feeder: fetches 64-bit words from a memory read port and serializes
// them LSB-byte-first onto stream_data/stream_valid, throttled by busy.
// Define STREAM_FEEDER_LOOP_EN to add looping playback (loop / loop_count).
module stream_feeder
  import stream_feeder_pkg::*;
#(
  parameter int ADDR_W = 22,
  parameter int LEN_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
`ifdef STREAM_FEEDER_LOOP_EN
  input  logic              loop,
  output logic [15:0]       loop_count,
`endif
  input  logic              busy,
  output logic [7:0]        stream_data,
  output logic              stream_valid,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic [63:0]       mem_rd_dta,
  input  logic              mem_rd_dvalid,
  output logic              feeding,
  output logic              done,
  output logic [LEN_W-1:0]  byte_count
);

  localparam int IDX_SHIFT = $clog2(BYTES_PER_WORD);

  feed_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_bytes_q, rem_bytes_d;
  logic [LEN_W-1:0]  words_left_q, words_left_d;
  logic [LEN_W-1:0]  byte_count_q, byte_count_d;
  logic              outstanding_q, outstanding_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        stream_data_q, stream_data_d;
  logic              stream_valid_q, stream_valid_d;
  logic              done_q, done_d;
  logic              done_pend_q, done_pend_d;
`ifdef STREAM_FEEDER_LOOP_EN
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              loop_q, loop_d;
  logic [15:0]       loop_count_q, loop_count_d;
`endif

  logic [1:0]  buf_count;
  logic [63:0] buf_head;
  logic        buf_wr, buf_rd, buf_clear;
  logic        req, req_fire, emit, last_byte;

  // Number of 64-bit words needed to cover n bytes (rounded up).
  function automatic logic [LEN_W-1:0] words_for(input logic [LEN_W-1:0] n);
    return (n >> IDX_SHIFT) + LEN_W'(|n[IDX_SHIFT-1:0]);
  endfunction

  // Only one read may be in flight, and only when the buffer has room for it.
  assign req       = (state_q == FEED_RUN) && (words_left_q != '0) && !outstanding_q &&
                     ((buf_count + 2'(outstanding_q)) < 2'(BUF_DEPTH));
  assign req_fire  = req && mem_rd_ack;
  assign emit      = (state_q == FEED_RUN) && !busy && (buf_count != 2'd0) && !abort;
  assign last_byte = (rem_bytes_q == LEN_W'(1));
  assign buf_rd    = emit && ((idx_q == 3'(BYTES_PER_WORD - 1)) || last_byte);
  assign buf_wr    = mem_rd_dvalid && outstanding_q && (state_q == FEED_RUN);
  assign buf_clear = ((state_q == FEED_RUN) && abort) || ((state_q == FEED_IDLE) && start);

  feeder_word_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .clear   (buf_clear),
    .wr_en   (buf_wr),
    .wr_data (mem_rd_dta),
    .rd_en   (buf_rd),
    .count   (buf_count),
    .head    (buf_head)
  );

  // Next-state, request credit and serializer.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    rem_bytes_d    = rem_bytes_q;
    words_left_d   = words_left_q;
    byte_count_d   = byte_count_q;
    outstanding_d  = outstanding_q;
    idx_d          = idx_q;
    stream_data_d  = 8'd0;
    stream_valid_d = 1'b0;
    done_d         = done_pend_q;
    done_pend_d    = 1'b0;
`ifdef STREAM_FEEDER_LOOP_EN
    base_d         = base_q;
    len_d          = len_q;
    loop_d         = loop_q;
    loop_count_d   = loop_count_q;
`endif

    // Returned data retires the read; a new acked request opens one.
    if (mem_rd_dvalid && outstanding_q) outstanding_d = 1'b0;
    if (req_fire) begin
      outstanding_d = 1'b1;
      addr_d        = addr_q + ADDR_W'(1);
      words_left_d  = words_left_q - LEN_W'(1);
    end

    case (state_q)
      FEED_IDLE: begin
        if (start) begin
          addr_d       = base_addr;
          rem_bytes_d  = length;
          words_left_d = words_for(length);
          byte_count_d = '0;
          idx_d        = 3'd0;
`ifdef STREAM_FEEDER_LOOP_EN
          base_d       = base_addr;
          len_d        = length;
          loop_d       = loop;
          loop_count_d = 16'd0;
`endif
          if (length == '0) done_d = 1'b1;
          else              state_d = FEED_RUN;
        end
      end

      FEED_RUN: begin
        if (abort) begin
          // A read accepted in this very cycle still has to be drained.
          state_d = outstanding_d ? FEED_FLUSH : FEED_IDLE;
          idx_d   = 3'd0;
        end else if (emit) begin
          stream_data_d  = buf_head[{idx_q, 3'b000} +: 8];
          stream_valid_d = 1'b1;
          byte_count_d   = byte_count_q + LEN_W'(1);
          rem_bytes_d    = rem_bytes_q - LEN_W'(1);
          idx_d          = buf_rd ? 3'd0 : idx_q + 3'd1;
          if (last_byte) begin
`ifdef STREAM_FEEDER_LOOP_EN
            if (loop_q) begin
              // All words were fetched before the last byte, so nothing is in flight.
              rem_bytes_d  = len_q;
              words_left_d = words_for(len_q);
              addr_d       = base_q;
              loop_count_d = loop_count_q + 16'd1;
            end else begin
              state_d     = FEED_IDLE;
              done_pend_d = 1'b1;
            end
`else
            state_d     = FEED_IDLE;
            done_pend_d = 1'b1;
`endif
          end
        end
      end

      FEED_FLUSH: begin
        if (!outstanding_d) state_d = FEED_IDLE;
      end

      default: state_d = FEED_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= FEED_IDLE;
      addr_q         <= '0;
      rem_bytes_q    <= '0;
      words_left_q   <= '0;
      byte_count_q   <= '0;
      outstanding_q  <= 1'b0;
      idx_q          <= 3'd0;
      stream_data_q  <= 8'd0;
      stream_valid_q <= 1'b0;
      done_q         <= 1'b0;
      done_pend_q    <= 1'b0;
`ifdef STREAM_FEEDER_LOOP_EN
      base_q         <= '0;
      len_q          <= '0;
      loop_q         <= 1'b0;
      loop_count_q   <= 16'd0;
`endif
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      rem_bytes_q    <= rem_bytes_d;
      words_left_q   <= words_left_d;
      byte_count_q   <= byte_count_d;
      outstanding_q  <= outstanding_d;
      idx_q          <= idx_d;
      stream_data_q  <= stream_data_d;
      stream_valid_q <= stream_valid_d;
      done_q         <= done_d;
      done_pend_q    <= done_pend_d;
`ifdef STREAM_FEEDER_LOOP_EN
      base_q         <= base_d;
      len_q          <= len_d;
      loop_q         <= loop_d;
      loop_count_q   <= loop_count_d;
`endif
    end
  end

  assign stream_data  = stream_data_q;
  assign stream_valid = stream_valid_q;
  assign mem_rd_req   = req;
  assign mem_rd_addr  = addr_q;
  assign feeding      = (state_q != FEED_IDLE);
  assign done         = done_q;
  assign byte_count   = byte_count_q;
`ifdef STREAM_FEEDER_LOOP_EN
  assign loop_count   = loop_count_q;
`endif

endmodule

// File: tb/tb_stream_feeder.sv
// tb_stream_feeder: scoreboard bench for stream_feeder. A memory responder
// answers reads; expected bytes and request addresses are queued at start
// and compared as the DUT produces them.
module tb_stream_feeder;
  import stream_feeder_pkg::*;

  logic        clk, rst, start, abort, busy;
  logic [21:0] base_addr, mem_rd_addr;
  logic [31:0] length, byte_count;
  logic [7:0]  stream_data;
  logic        stream_valid, mem_rd_req, mem_rd_ack, mem_rd_dvalid, feeding, done;
  logic [63:0] mem_rd_dta;
`ifdef STREAM_FEEDER_LOOP_EN
  logic        loop;
  logic [15:0] loop_count;
`endif

  int          checks = 0, errors = 0, cycle = 0;
  logic [7:0]  exp_q[$];
  logic [21:0] req_q[$];
  bit          done_arm = 0, expect_done = 0, prev_busy = 0, busy_mode = 0;
  int          done_due = 0, ack_delay = 0, dv_delay = 1, out_model = 0;

  stream_feeder #(.ADDR_W(22), .LEN_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length),
`ifdef STREAM_FEEDER_LOOP_EN
    .loop(loop), .loop_count(loop_count),
`endif
    .busy(busy), .stream_data(stream_data), .stream_valid(stream_valid),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
    .mem_rd_dta(mem_rd_dta), .mem_rd_dvalid(mem_rd_dvalid),
    .feeding(feeding), .done(done), .byte_count(byte_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Cycle counter: value k means "after posedge number k".
  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Memory contents: byte j of word a is the low byte of 8*a+j.
  function automatic logic [63:0] word_at(input logic [21:0] a);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'(int'(a) * 8 + j);
    return w;
  endfunction

  // Memory responder and busy pattern generator, driving just after each edge.
  initial begin : responder
    int       req_age, pend_cnt, busy_cnt;
    bit       pend, req_seen;
    logic [21:0] pend_addr, held_addr, e;
    req_age = 0; pend_cnt = 0; busy_cnt = 0; pend = 0; req_seen = 0;
    pend_addr = 0; held_addr = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        mem_rd_ack = 0; mem_rd_dvalid = 0; pend = 0; out_model = 0;
        req_age = 0; req_seen = 0;
      end else begin
        if (mem_rd_ack) out_model++;
        if (mem_rd_dvalid) out_model--;
        mem_rd_ack = 0; mem_rd_dvalid = 0; mem_rd_dta = 64'd0;
        if (out_model > 1) begin
          errors++;
          $display("FAIL outstanding: %0d reads in flight, required at most 1", out_model);
        end
        if (pend) begin
          if (pend_cnt <= 1) begin
            mem_rd_dvalid = 1; mem_rd_dta = word_at(pend_addr); pend = 0;
          end else pend_cnt--;
        end
        if (mem_rd_req) begin
          if (out_model != 0) begin
            checks++; errors++;
            $display("FAIL req_credit: req=1 with %0d outstanding, required req=0", out_model);
          end
          if (req_seen) begin
            checks++;
            if (mem_rd_addr !== held_addr) begin
              errors++;
              $display("FAIL addr_stable: addr %h while unacked, required %h", mem_rd_addr, held_addr);
            end
          end
          held_addr = mem_rd_addr; req_seen = 1;
          if (req_age >= ack_delay) begin
            mem_rd_ack = 1; pend = 1; pend_cnt = dv_delay; pend_addr = mem_rd_addr;
            req_seen = 0; req_age = 0;
            checks++;
            if (req_q.size() == 0) begin
              errors++;
              $display("FAIL req_addr: unexpected request to %h, required none", mem_rd_addr);
            end else begin
              e = req_q.pop_front();
              if (mem_rd_addr !== e) begin
                errors++;
                $display("FAIL req_addr: request to %h, required %h", mem_rd_addr, e);
              end
            end
          end else req_age++;
        end else begin
          req_seen = 0; req_age = 0;
        end
      end
      if (busy_mode) begin
        busy = ((busy_cnt / 3) % 2) == 1;
        busy_cnt++;
      end
    end
  end

  // Output monitor: byte scoreboard, busy rule, done timing, buffer bounds.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (stream_valid) begin
          checks++;
          if (prev_busy) begin
            errors++;
            $display("FAIL busy_rule: byte %h at cycle %0d after busy=1, required no byte", stream_data, cycle);
          end
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream_byte: unexpected byte %h at cycle %0d, required none", stream_data, cycle);
          end else begin
            e = exp_q.pop_front();
            if (stream_data !== e) begin
              errors++;
              $display("FAIL stream_byte: got %h at cycle %0d, required %h", stream_data, cycle, e);
            end else
              $display("byte %h at cycle %0d", stream_data, cycle);
            if (exp_q.size() == 0 && done_arm) begin
              expect_done = 1; done_due = cycle + 1; done_arm = 0;
            end
          end
        end
        if (done) begin
          checks++;
          if (!(expect_done && cycle == done_due)) begin
            errors++;
            $display("FAIL done_pulse: done=1 at cycle %0d, required at cycle %0d (armed=%0b)", cycle, done_due, expect_done);
          end
          expect_done = 0;
        end else if (expect_done && cycle > done_due) begin
          checks++; errors++;
          $display("FAIL done_pulse: done=0 at cycle %0d, required 1 at cycle %0d", cycle, done_due);
          expect_done = 0;
        end
        if (dut.u_buf.count > 2'd2 || (mem_rd_dvalid && dut.u_buf.count == 2'd2 && dut.state_q == FEED_RUN)) begin
          checks++; errors++;
          $display("FAIL buf_count: count=%0d dvalid=%0b, required count<=2 and no write when full", dut.u_buf.count, mem_rd_dvalid);
        end
      end
      prev_busy = busy;
    end
  end

  // Watchdog in case something escapes the bounded waits.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic start_clip(input logic [21:0] b, input logic [31:0] len, input bit arm);
    @(posedge clk); #1;
    for (int i = 0; i < int'(len); i++) exp_q.push_back(8'(int'(b) * 8 + i));
    for (int k = 0; k < (int'(len) + 7) / 8; k++) req_q.push_back(b + 22'(k));
    done_arm = arm && (len != 0);
    if (len == 0) begin
      expect_done = arm; done_due = cycle + 1;
    end
    start = 1; base_addr = b; length = len;
    $display("start base=%h len=%0d", b, len);
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int n = 0;
    while ((feeding || exp_q.size() != 0 || expect_done) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: feeding=%0b pending=%0d after %0d cycles, required idle", name, feeding, exp_q.size(), n);
    end
    checks++;
    if (req_q.size() != 0) begin
      errors++;
      $display("FAIL %s_requests: %0d requests missing, required 0", name, req_q.size());
    end
  endtask

  task automatic wait_count(input logic [31:0] target, input int budget, input string name);
    int n = 0;
    while (byte_count != target && n < budget) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (byte_count !== target) begin
      errors++;
      $display("FAIL %s_wait: byte_count=%0d, required %0d", name, byte_count, target);
    end
  endtask

  task automatic check_count(input logic [31:0] want, input string name);
    checks++;
    if (byte_count !== want) begin
      errors++;
      $display("FAIL %s_byte_count: got %0d, required %0d", name, byte_count, want);
    end else $display("%s byte_count=%0d", name, byte_count);
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({stream_data, stream_valid, mem_rd_req, mem_rd_addr, feeding, done, byte_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: data=%h v=%b req=%b addr=%h feed=%b done=%b cnt=%0d, required all 0",
               stream_data, stream_valid, mem_rd_req, mem_rd_addr, feeding, done, byte_count);
    end else $display("reset state ok");
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_basic();
    ack_delay = 0; dv_delay = 1;
    start_clip(22'h100, 20, 1);
    wait_quiet(400, "basic");
    check_count(20, "basic");
  endtask

  task automatic test_busy();
    busy_mode = 1;
    start_clip(22'h100, 20, 1);
    wait_quiet(600, "busy");
    busy_mode = 0; busy = 0;
    check_count(20, "busy");
  endtask

  task automatic test_zero();
    start_clip(22'h100, 0, 1);
    wait_quiet(20, "zero");
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (feeding !== 1'b0 || mem_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle: feeding=%b req=%b, required 0 0", feeding, mem_rd_req);
    end
    check_count(0, "zero");
  endtask

  task automatic test_slow();
    ack_delay = 5; dv_delay = 10;
    start_clip(22'h300, 64, 1);
    wait_quiet(3000, "slow");
    check_count(64, "slow");
    ack_delay = 0; dv_delay = 1;
  endtask

  task automatic test_abort();
    ack_delay = 0; dv_delay = 12;
    start_clip(22'h100, 64, 0);
    wait_count(11, 500, "abort");
    checks++;
    if (out_model != 1) begin
      errors++;
      $display("FAIL abort_outstanding: %0d reads in flight at abort, required 1", out_model);
    end
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    exp_q.delete(); req_q.delete();
    checks++;
    if (feeding !== 1'b1) begin
      errors++;
      $display("FAIL abort_flush: feeding=%b after abort, required 1", feeding);
    end else $display("abort -> flushing");
    wait_quiet(100, "abort");
    check_count(11, "abort");
    dv_delay = 1;
    start_clip(22'h205, 8, 1);
    wait_quiet(200, "fresh");
    check_count(8, "fresh");
  endtask

  task automatic test_reset_midrun();
    start_clip(22'h100, 64, 0);
    wait_count(5, 300, "midrun");
    rst = 0;
    exp_q.delete(); req_q.delete();
    done_arm = 0; expect_done = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({stream_data, stream_valid, mem_rd_req, mem_rd_addr, feeding, done, byte_count} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: data=%h v=%b req=%b addr=%h feed=%b done=%b cnt=%0d, required all 0",
               stream_data, stream_valid, mem_rd_req, mem_rd_addr, feeding, done, byte_count);
    end else $display("mid-run reset ok");
    @(posedge clk); #1;
    rst = 1;
    start_clip(22'h205, 8, 1);
    wait_quiet(200, "recover");
    check_count(8, "recover");
  endtask

`ifdef STREAM_FEEDER_LOOP_EN
  task automatic test_loop();
    loop = 1;
    start_clip(22'h100, 9, 0);
    loop = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 9; i++) if (r < 2) exp_q.push_back(8'(i));
      req_q.push_back(22'h100); req_q.push_back(22'h101);
    end
    wait_count(9, 300, "loop1");
    checks++;
    if (loop_count !== 16'd1) begin
      errors++;
      $display("FAIL loop_count: got %0d after 9 bytes, required 1", loop_count);
    end
    wait_count(27, 600, "loop3");
    checks++;
    if (loop_count !== 16'd3) begin
      errors++;
      $display("FAIL loop_count: got %0d after 27 bytes, required 3", loop_count);
    end else $display("loop_count=%0d", loop_count);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    exp_q.delete(); req_q.delete();
    wait_quiet(100, "loop");
  endtask
`endif

  initial begin
    rst = 0; start = 0; abort = 0; busy = 0; base_addr = 0; length = 0;
    mem_rd_ack = 0; mem_rd_dvalid = 0; mem_rd_dta = 0;
`ifdef STREAM_FEEDER_LOOP_EN
    loop = 0;
`endif
    test_reset();
    test_basic();
    test_busy();
    test_zero();
    test_slow();
    test_abort();
    test_reset_midrun();
`ifdef STREAM_FEEDER_LOOP_EN
    test_loop();
`endif
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_feeder.md
Name: stream_feeder

Overview:
Synthesizable replacement for the bench-side byte source of the mpeg2video stream input. Fetches 64-bit words from a memory read port and serializes them LSB-byte-first onto stream_data/stream_valid, throttled by the decoder's busy. Sits between the DRAM/SD read path and mpeg2video. Software controls it with start/abort, a base word address and a byte length.

Parameters:
ADDR_W, 22, word (64-bit) address width of the memory read port
LEN_W, 32, width of byte length and byte counters

Ports:
clk  in  1  system clock (same domain as mpeg2video clk)
rst  in  1  synchronous reset, active-low
start  in  1  one-cycle pulse; latch base_addr/length and begin feeding
abort  in  1  one-cycle pulse; stop feeding, discard buffered data
base_addr  in  ADDR_W  first word address of the clip
length  in  LEN_W  clip length in bytes
busy  in  1  decoder input back-pressure (mpeg2video busy)
stream_data  out  8  byte to decoder
stream_valid  out  1  stream_data valid this cycle
mem_rd_req  out  1  read request, held until acked
mem_rd_addr  out  ADDR_W  word address of the request
mem_rd_ack  in  1  request accepted (one cycle)
mem_rd_dta  in  64  returned word
mem_rd_dvalid  in  1  mem_rd_dta valid (one cycle, in request order)
feeding  out  1  state != IDLE
done  out  1  one-cycle pulse after the last byte is emitted
byte_count  out  LEN_W  bytes emitted since the last start

Behaviour:
- Reset (rst==0 at clk edge): state IDLE; stream_data=0, stream_valid=0, mem_rd_req=0, mem_rd_addr=0, feeding=0, done=0, byte_count=0; word buffer empty; outstanding=0.
- States: IDLE, RUN, FLUSH.
- IDLE: start -> latch base/length; byte_count=0; rem_bytes=length; words_left=ceil(length/8); RUN. If length==0, done pulses next cycle and the block stays IDLE. start is ignored outside IDLE.
- RUN: abort -> FLUSH if outstanding!=0, else IDLE. Buffer is cleared in both cases; no done pulse.
- FLUSH: drop every mem_rd_dvalid. Go IDLE when outstanding reaches 0. start is ignored.
- Request credit rule:
  - mem_rd_req asserts when state==RUN, words_left!=0, outstanding==0 and buf_count+outstanding<2.
  - On req&ack: outstanding=1, mem_rd_addr+=1, words_left-=1. Req and addr are stable until ack.
- Word buffer: 2 entries. The dvalid write and the head pop may occur in the same cycle; buf_count is then unchanged. dvalid while the buffer is full is a protocol violation; the bench asserts on it.
- Emission:
  - Registered. At an edge where state==RUN, busy==0, buffer non-empty and no abort: stream_data <= head[8*idx+:8], stream_valid <= 1, idx += 1, rem_bytes -= 1, byte_count += 1.
  - Otherwise stream_data <= 0, stream_valid <= 0.
  - Latency: busy low at edge N gives the byte valid in cycle N+1. The same timing applies to the first byte after data arrives.
- Pop head when idx==7 or rem_bytes==1; idx resets to 0.
- Last word: only rem_bytes bytes are sent; the upper bytes are discarded.
- When the emit makes rem_bytes 0: state -> IDLE and done=1 for one cycle. byte_count holds its value until the next start.
- abort and the final emit in the same cycle: abort wins; that byte is not sent and done does not pulse.

Optional Feature:
STREAM_FEEDER_LOOP_EN
- Defined: input loop (1 bit) is latched at start. When the final byte is emitted with loop=1, the block does not go IDLE or pulse done. It reloads rem_bytes, words_left and mem_rd_addr from the latched values and continues with no gap beyond refetch latency. byte_count keeps counting and wraps modulo 2^LEN_W. An output loop_count[15:0] increments per wrap and clears on start.
- Undefined: no loop port, no loop_count; the clip plays once.

Decomposition:
- Shared include stream_feeder_defs.v holds:
  - state encodings FEED_IDLE=2'd0, FEED_RUN=2'd1, FEED_FLUSH=2'd2
  - BYTES_PER_WORD=8
  - BUF_DEPTH=2
- One sub-module, feeder_word_buf: 2-entry 64-bit FIFO with wr/rd/clear, count, head. The top level keeps the FSM, request credit and serializer.

Test Plan:
- base_addr=0x100, length=20, memory word k = bytes {8k+7..8k}, busy=0 -> requests to 0x100, 0x101, 0x102 only; bytes 0x00..0x13 in order; done one cycle after byte 0x13; byte_count=20.
- Same clip with busy toggling every 3 cycles -> a valid byte appears only in the cycle after busy was low; no byte lost or duplicated; byte_count=20.
- length=0 -> no mem_rd_req, no stream_valid, done one cycle after start.
- length=64, ack delayed 5 cycles, dvalid 10 cycles after ack -> mem_rd_addr stable while req is unacked; outstanding never exceeds 1; buf_count never exceeds 2; all 64 bytes delivered.
- abort after 11 bytes with a read outstanding -> state FLUSH; late dvalid dropped; state IDLE; no done; a new start with length=8 outputs only the fresh word.
- rst low mid-RUN -> all outputs 0 on the next edge. With STREAM_FEEDER_LOOP_EN, loop=1, length=9: bytes 0..8 repeat and loop_count increments every 9 bytes.
